// File: rtl/pipe_pkg.sv
// Shared types and constants for the npc pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_DATA_W = 256;
  localparam int unsigned PIPE_CNT_W  = 32;
  localparam logic [63:0] PIPE_RST_PC = 64'h0000_0000_8000_0000;

  // EX stage bundle; packed into DATA_W at the instance, PC reset via RST_VAL.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_ren;
    logic        mem_wen;
  } ex_bundle_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// Second storage entry of the skid-mode stage register: data word plus valid bit.
module pipe_skid_entry #(
  parameter int unsigned          DATA_W  = 256,
  parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear wins over load so a flush never leaves a stale skid beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int unsigned       CNT_W   = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

`ifdef PIPE_STAGE_SKID_EN

  pipe_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              skid_load_s, skid_clear_s, skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;
  logic              accept_s, drain_s;

  // Ready is purely registered; only flush can mask it combinationally.
  assign in_ready = in_ready_q && !flush;
  assign accept_s = in_valid && in_ready;
  assign drain_s  = main_valid_q && out_ready;

  pipe_skid_entry #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load_s),
    .clear (skid_clear_s),
    .d     (in_data),
    .valid (skid_valid_s),
    .q     (skid_data_s)
  );

  // EMPTY/FULL/SKID next state, main entry load and skid control.
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (flush) begin
      state_d      = EMPTY;
      skid_clear_s = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            state_d     = FULL;
            main_data_d = in_data;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (accept_s && drain_s) begin
            main_data_d = in_data;
          end else if (accept_s) begin
            state_d     = SKID;
            skid_load_s = 1'b1;
          end else if (drain_s) begin
            state_d = EMPTY;
          end else begin
            state_d = FULL;
          end
        end
        SKID: begin
          if (drain_s) begin
            state_d      = skid_valid_s ? FULL : EMPTY;
            main_data_d  = skid_data_s;
            skid_clear_s = 1'b1;
          end else begin
            state_d = SKID;
          end
        end
        default: begin
          state_d      = EMPTY;
          skid_clear_s = 1'b1;
        end
      endcase
    end
    main_valid_d = (state_d != EMPTY);
    in_ready_d   = (state_d != SKID);
  end

  // FSM state and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

`else

  assign in_ready = (!main_valid_q || out_ready) && !flush;

  // Single entry: a drain and an accept in the same cycle replace the beat.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
  end

`endif

  // Stall counter saturates instead of wrapping; only rst clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Main entry and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RST_VAL;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (base mode, or skid mode with PIPE_STAGE_SKID_EN).
module tb_pipe_stage_reg;

  localparam int unsigned       DW  = 16;
  localparam int unsigned       CW  = 3;
  localparam logic [DW-1:0]     RV  = 16'hBEEF;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_reg #(.DATA_W(DW), .RST_VAL(RV), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0000;
    step(); step();
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (out_data !== RV) begin n_fail++; $display("FAIL reset_data got %h want %h", out_data, RV); end
    n_tests++; if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = 16'h1000 + DW'(i);
      in_valid = 1'b1; in_data = exp;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready beat %0d got %b want 1", i, in_ready); end
      step();
      n_tests++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL stream_out beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp); end
      n_tests++; if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL stream_cnt beat %0d got %0d want 0", i, stall_cnt); end
    end
    in_valid = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    int accepted;
    int exp_acc;
`ifdef PIPE_STAGE_SKID_EN
    exp_acc = 1;
`else
    exp_acc = 0;
`endif
    accepted = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h2222;
    step();
    in_data = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      if (in_valid && in_ready) accepted++;
      step();
      n_tests++; if (out_valid !== 1'b1 || out_data !== 16'h2222) begin n_fail++; $display("FAIL stall_hold cyc %0d got v=%b d=%h want v=1 d=2222", i, out_valid, out_data); end
    end
    n_tests++; if (stall_cnt !== 3'd5) begin n_fail++; $display("FAIL stall_cnt got %0d want 5", stall_cnt); end
    n_tests++; if (accepted != exp_acc) begin n_fail++; $display("FAIL stall_absorb got %0d want %0d", accepted, exp_acc); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
`ifdef PIPE_STAGE_SKID_EN
    n_tests++; if (out_valid !== 1'b1 || out_data !== 16'h3333) begin n_fail++; $display("FAIL skid_release got v=%b d=%h want v=1 d=3333", out_valid, out_data); end
    step();
`endif
    n_tests++; if (out_valid !== 1'b0 || stall_cnt !== 3'd5) begin n_fail++; $display("FAIL stall_release got v=%b cnt=%0d want v=0 cnt=5", out_valid, stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h4444;
    step();
    flush = 1'b1; in_data = 16'h00A5;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_tests++; if (stall_cnt !== 3'd5) begin n_fail++; $display("FAIL flush_cnt got %0d want 5", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak cyc %0d got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h5001;
    step();
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      in_data = 16'h5000 + DW'(i);
      step();
      n_tests++; if (out_valid !== 1'b1 || out_data !== (16'h5000 + DW'(i))) begin n_fail++; $display("FAIL b2b beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 16'h5000 + DW'(i)); end
    end
    in_valid = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_saturate();
    logic [CW-1:0] exp;
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h6666;
    step();
    in_valid = 1'b0;
    exp = 3'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (exp != 3'd7) exp = exp + 3'd1;
      n_tests++; if (stall_cnt !== exp) begin n_fail++; $display("FAIL sat_cnt cyc %0d got %0d want %0d", i, stall_cnt, exp); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || out_data !== RV || stall_cnt !== 3'd0) begin n_fail++; $display("FAIL midrst got v=%b d=%h cnt=%0d want v=0 d=%h cnt=0", out_valid, out_data, stall_cnt, RV); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register with a valid/ready handshake, synchronous flush and a saturating stall counter. It replaces the per-stage hand-written enable registers between IF/ID/EX/MEM/WB in the npc core: each stage packs its control and data fields into one payload vector, and this block carries that vector to the next stage. Optionally, a second skid entry registers the upstream ready to cut the combinational ready chain across stages.

## Interface
Parameters:
- DATA_W, 256: payload width in bits; must be at least 1.
- RST_VAL, '0 (DATA_W bits): payload value loaded on reset. The EX bundle sets the PC field to 64'h80000000 through this.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discards all held beats (branch mispredict or trap).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  beat held for downstream.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  DATA_W  held payload.
- stall_cnt  out  CNT_W  count of cycles with out_valid && !out_ready.

## Operation
- Transfer rules:
  - Upstream accept: in_valid && in_ready, sampled at the edge.
  - Downstream accept: out_valid && out_ready.
- Flush:
  - Forces in_ready = 0 in the same cycle.
  - Clears all valid bits at the next edge.
  - Payload registers keep their old values, and out_data is don't-care while out_valid = 0.
  - Takes priority over simultaneous accept and drain.
- out_data is stable while out_valid && !out_ready. Once asserted, valid stays asserted until the beat is taken or flushed.
- Base mode (no macro):
  - One entry. in_ready = (!out_valid || out_ready) && !flush, combinational.
  - Simultaneous drain and accept replaces the entry in one cycle, giving full throughput.
- Skid mode: states EMPTY, FULL, SKID (main + skid entries occupied).
  - EMPTY: accept → FULL.
  - FULL: accept without drain → SKID, with the new beat going into the skid entry. Drain without accept → EMPTY. Accept with drain → FULL, loading the new beat into main.
  - SKID: in_ready = 0. Drain → FULL, moving skid to main.
  - flush from any state → EMPTY.
- Stall counter:
  - Increments each cycle with out_valid && !out_ready && !flush.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst; flush does not clear it.

## Timing
- Values after rst:
  - out_valid = 0, out_data = RST_VAL, stall_cnt = 0, state EMPTY.
  - in_ready = 1 in the cycle after reset.
  - rst in mid-stream drops any held beats with no output handshake.
- Latency: 1 cycle from an upstream accept to out_valid, in both modes.
- Throughput: 1 beat/cycle while downstream is ready.
- Ready timing:
  - Base mode: in_ready depends combinationally on out_ready and flush.
  - Skid mode: in_ready is a register output ANDed only with !flush. There is no path from out_ready to in_ready.
- Skid mode absorbs exactly one beat after out_ready falls.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid mode with the EMPTY/FULL/SKID FSM and registered ready, as above.
- PIPE_STAGE_SKID_EN undefined: single-entry base mode with no skid storage. The ports and stall_cnt behaviour are identical in both modes.

## Structure
- Package pipe_pkg holds:
  - state enum pipe_state_e {EMPTY, FULL, SKID};
  - default DATA_W and CNT_W constants;
  - the reset PC constant 64'h80000000.
- Per-stage payload structs (e.g. EX bundle) live in pipe_pkg and are packed to DATA_W at the instance.
- Sub-module pipe_skid_entry holds the skid data register and its valid bit. It is instantiated only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset, then stream 8 beats with out_ready = 1: out_data follows in_data with 1-cycle lag, in_ready stays 1, stall_cnt = 0.
- Hold out_ready = 0 for 5 cycles with a beat held: out_data stays constant and stall_cnt = 5. In skid mode, exactly one extra beat is accepted and then in_ready = 0.
- flush during an accept of in_data = 0xA5: next cycle out_valid = 0, and 0xA5 is never presented. stall_cnt keeps its value.
- Simultaneous drain and accept in FULL (base mode and skid mode): out_valid stays 1 and out_data updates to the new beat in one cycle, with no bubble.
- Use CNT_W = 3 and stall 10 cycles: stall_cnt saturates at 7. Assert rst mid-stall: next cycle out_valid = 0, out_data = RST_VAL and stall_cnt = 0.
